mdu_ctrl: RTL
=============

Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide control and HI/LO unit in the E stage of the 5-stage MIPS pipeline.
- Decodes MDU instructions and runs a latency counter for mult/div, modelling multi-cycle hardware.
- Owns the HI/LO registers, supplies mfhi/mflo read data, and raises a stall request to the hazard unit while an operation is in flight.

Parameters:
- MUL_CYCLES, 5, busy cycles for mult/multu (and madd family when enabled); legal range >=1
- DIV_CYCLES, 10, busy cycles for div/divu; legal range >=1

Ports:
- clk  input  1  pipeline clock
- reset_n  input  1  asynchronous active-low reset
- instr  input  32  E-stage instruction word
- in_valid  input  1  E-stage instruction is real (not a bubble, not stalled)
- cancel  input  1  abort the in-flight op (exception or flush)
- rs_data  input  32  forwarded rs operand
- rt_data  input  32  forwarded rt operand
- busy  output  1  operation in flight
- stall  output  1  stall request to the hazard unit
- hi  output  32  HI register
- lo  output  32  LO register
- mf_data  output  32  mfhi/mflo result for the E-stage ALU-out mux
- mf_sel  output  1  E-stage instruction is mfhi or mflo (selects mf_data)

Behaviour:
- Decode, R-type (op 000000), by func:
  - mult 011000, multu 011001, div 011010, divu 011011
  - mfhi 010000, mflo 010010, mthi 010001, mtlo 010011
- md_any is the OR of these eight decodes.
- States: IDLE and BUSY. A counter of width clog2(max(MUL_CYCLES,DIV_CYCLES))+1 bits counts the busy cycles.
- Start: in IDLE with in_valid, !cancel and a mult/multu/div/divu:
  - compute the result combinationally and latch it into staging registers res_hi/res_lo;
  - load the counter with MUL_CYCLES or DIV_CYCLES;
  - go to BUSY on that edge.
- BUSY:
  - counter decrements each edge;
  - on the edge where counter==1, hi<=res_hi, lo<=res_lo, state goes to IDLE.
- busy is high for exactly N cycles after the start edge. New hi/lo values are visible on the first cycle busy is low.
- Arithmetic:
  - mult: signed 64-bit product; multu: unsigned. hi=[63:32], lo=[31:0].
  - div: signed, lo=quotient, hi=remainder, remainder takes the sign of the dividend. divu: unsigned.
  - Divisor==0: the op still runs DIV_CYCLES, and hi/lo are left unchanged on completion.
  - Signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- mthi/mtlo in IDLE with in_valid: hi<=rs_data (or lo<=rs_data) at the next edge. No busy.
- mfhi/mflo:
  - mf_data = hi or lo, combinational from the current registers;
  - mf_sel = in_valid & (mfhi|mflo).
- stall = in_valid & md_any & busy. No MDU instruction is accepted while busy; the stalled instruction re-presents.
- cancel:
  - in BUSY, go to IDLE on the next edge and discard staging; hi/lo unchanged;
  - cancel with a start in the same cycle: cancel wins and no op starts;
  - cancel also suppresses mthi/mtlo writes.
- Completion with a new MDU instruction in the same cycle: stall stays high in that cycle (busy still high), so the new instruction is accepted the next cycle.
- Reset (asynchronous, any time including mid-op): state=IDLE, counter=0, hi=0, lo=0, staging=0, busy=0. stall=0 and mf_sel=0 follow combinationally.

Optional Feature:
- Macro MDU_MADD_EN.
- When defined, decode the SPECIAL2 ops (op 011100): madd func 000000, maddu 000001, msub 000100, msubu 000101.
- The result {hi,lo} ± (rs*rt), signed or unsigned, is computed at start from the current hi/lo and committed after MUL_CYCLES. These ops are included in md_any, stall and cancel.
- When not defined, these encodings are not MDU instructions: no stall, no hi/lo effect.

Test Plan:
- mult, rs=0xFFFFFFFE, rt=3, MUL_CYCLES=5:
  - busy high for 5 cycles;
  - then hi=0xFFFFFFFF, lo=0xFFFFFFFA;
  - an mflo presented during busy gets stall=1 until the cycle after completion, then mf_data=0xFFFFFFFA.
- div rs=0xFFFFFFF9 (-7), rt=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 cycles. divu with the same operands: lo=0x7FFFFFFC, hi=1.
- div, rt=0, with prior hi=0x11, lo=0x22: busy 10 cycles, then hi=0x11, lo=0x22 unchanged. Signed 0x80000000/-1 gives lo=0x80000000, hi=0.
- mult started, cancel asserted on busy cycle 2: busy low next cycle, hi/lo keep their old values, and the next mult starts immediately.
- mthi rs=0xDEADBEEF then mfhi: mf_data=0xDEADBEEF the next cycle with no stall. reset_n pulsed low mid-div: hi=lo=0 and busy=0 immediately, without waiting for a clock edge.
- With MDU_MADD_EN: hi=0, lo=10, madd rs=-2, rt=3 gives hi=0, lo=4 after MUL_CYCLES. Without the macro the same word produces no stall and no change to hi/lo.

Source files
------------

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide control and HI/LO register unit for the E stage.
// Decodes MDU instructions and models multi-cycle hardware with a latency
// counter. The result is computed when the op starts, held in staging
// registers, and committed to HI/LO once the latency has elapsed.
//
// Optional build macro: MDU_MADD_EN adds the SPECIAL2 madd/maddu/msub/msubu ops.
//
// Ports:
//   clk, reset_n        pipeline clock, asynchronous active-low reset
//   instr, in_valid     E-stage instruction word and its valid qualifier
//   cancel              abort the in-flight op (exception or flush)
//   rs_data, rt_data    forwarded operands
//   busy, stall         op in flight / stall request to the hazard unit
//   hi, lo              architectural HI/LO registers
//   mf_data, mf_sel     mfhi/mflo read data and its select for the ALU-out mux
module mdu_ctrl #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr,
    input  logic        in_valid,
    input  logic        cancel,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_data,
    output logic        mf_sel
);
    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES) + 1;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    state_t        state_r, state_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic [31:0]   hi_r, lo_r, res_hi_r, res_lo_r;

    logic dec_mult_s, dec_multu_s, dec_div_s, dec_divu_s;
    logic dec_mfhi_s, dec_mflo_s, dec_mthi_s, dec_mtlo_s;
    logic dec_madd_s, dec_maddu_s, dec_msub_s, dec_msubu_s;
    logic md_any_s, dec_start_s, start_s, start_div_s;
    logic wr_hi_s, wr_lo_s, load_res_s, commit_s, clr_res_s;
    logic unused_instr_s;

    logic [63:0] mul_a_s, mul_b_s, prod_s, res_nxt_s;
    logic        neg_a_s, neg_b_s;
    logic [31:0] mag_a_s, mag_b_s, div_den_s, uq_s, ur_s, quot_s, rem_s;

    // Only the opcode and function fields take part in decoding.
    assign unused_instr_s = ^instr[25:6];

    assign dec_mult_s  = (instr[31:26] == 6'b000000) && (instr[5:0] == 6'b011000);
    assign dec_multu_s = (instr[31:26] == 6'b000000) && (instr[5:0] == 6'b011001);
    assign dec_div_s   = (instr[31:26] == 6'b000000) && (instr[5:0] == 6'b011010);
    assign dec_divu_s  = (instr[31:26] == 6'b000000) && (instr[5:0] == 6'b011011);
    assign dec_mfhi_s  = (instr[31:26] == 6'b000000) && (instr[5:0] == 6'b010000);
    assign dec_mflo_s  = (instr[31:26] == 6'b000000) && (instr[5:0] == 6'b010010);
    assign dec_mthi_s  = (instr[31:26] == 6'b000000) && (instr[5:0] == 6'b010001);
    assign dec_mtlo_s  = (instr[31:26] == 6'b000000) && (instr[5:0] == 6'b010011);
`ifdef MDU_MADD_EN
    assign dec_madd_s  = (instr[31:26] == 6'b011100) && (instr[5:0] == 6'b000000);
    assign dec_maddu_s = (instr[31:26] == 6'b011100) && (instr[5:0] == 6'b000001);
    assign dec_msub_s  = (instr[31:26] == 6'b011100) && (instr[5:0] == 6'b000100);
    assign dec_msubu_s = (instr[31:26] == 6'b011100) && (instr[5:0] == 6'b000101);
`else
    assign dec_madd_s  = 1'b0;
    assign dec_maddu_s = 1'b0;
    assign dec_msub_s  = 1'b0;
    assign dec_msubu_s = 1'b0;
`endif

    assign start_div_s = dec_div_s | dec_divu_s;
    assign dec_start_s = dec_mult_s | dec_multu_s | start_div_s |
                         dec_madd_s | dec_maddu_s | dec_msub_s | dec_msubu_s;
    assign md_any_s    = dec_start_s | dec_mfhi_s | dec_mflo_s | dec_mthi_s | dec_mtlo_s;

    assign start_s = (state_r == ST_IDLE) && in_valid && !cancel && dec_start_s;
    assign wr_hi_s = (state_r == ST_IDLE) && in_valid && !cancel && dec_mthi_s;
    assign wr_lo_s = (state_r == ST_IDLE) && in_valid && !cancel && dec_mtlo_s;

    assign busy    = (state_r == ST_BUSY);
    assign stall   = in_valid && md_any_s && busy;
    assign mf_sel  = in_valid && (dec_mfhi_s || dec_mflo_s);
    assign mf_data = dec_mfhi_s ? hi_r : lo_r;
    assign hi      = hi_r;
    assign lo      = lo_r;

    // Arithmetic: one 64-bit multiplier (sign/zero extended operands) and a
    // magnitude divider whose quotient/remainder signs are restored afterwards.
    always_comb begin
        mul_a_s = {((dec_mult_s | dec_madd_s | dec_msub_s) && rs_data[31]) ? 32'hFFFF_FFFF : 32'h0, rs_data};
        mul_b_s = {((dec_mult_s | dec_madd_s | dec_msub_s) && rt_data[31]) ? 32'hFFFF_FFFF : 32'h0, rt_data};
        prod_s  = mul_a_s * mul_b_s;

        neg_a_s   = dec_div_s && rs_data[31];
        neg_b_s   = dec_div_s && rt_data[31];
        mag_a_s   = neg_a_s ? (32'd0 - rs_data) : rs_data;
        mag_b_s   = neg_b_s ? (32'd0 - rt_data) : rt_data;
        // Keep the divider away from a zero divisor; that result is never used.
        div_den_s = (mag_b_s == 32'd0) ? 32'd1 : mag_b_s;
        uq_s      = mag_a_s / div_den_s;
        ur_s      = mag_a_s % div_den_s;
        quot_s    = (neg_a_s ^ neg_b_s) ? (32'd0 - uq_s) : uq_s;
        rem_s     = neg_a_s ? (32'd0 - ur_s) : ur_s;

        if (dec_mult_s || dec_multu_s) begin
            res_nxt_s = prod_s;
        end else if (start_div_s) begin
            // Divide by zero commits the current HI/LO, i.e. leaves them unchanged.
            res_nxt_s = (rt_data == 32'd0) ? {hi_r, lo_r} : {rem_s, quot_s};
        end else if (dec_madd_s || dec_maddu_s) begin
            res_nxt_s = {hi_r, lo_r} + prod_s;
        end else if (dec_msub_s || dec_msubu_s) begin
            res_nxt_s = {hi_r, lo_r} - prod_s;
        end else begin
            res_nxt_s = {hi_r, lo_r};
        end
    end

    // FSM state and latency counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic: start loads the latency, cancel aborts, count 1 commits.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        load_res_s  = 1'b0;
        commit_s    = 1'b0;
        clr_res_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = ST_BUSY;
                    cnt_nxt_s   = start_div_s ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                    load_res_s  = 1'b1;
                end else begin
                    cnt_nxt_s   = {CW{1'b0}};
                end
            end
            ST_BUSY: begin
                if (cancel) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {CW{1'b0}};
                    clr_res_s   = 1'b1;
                end else if (cnt_r == CW'(1)) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {CW{1'b0}};
                    commit_s    = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r - CW'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CW{1'b0}};
            end
        endcase
    end

    // Staging and HI/LO registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_hi_r <= 32'd0;
            res_lo_r <= 32'd0;
            hi_r     <= 32'd0;
            lo_r     <= 32'd0;
        end else begin
            if (load_res_s) begin
                res_hi_r <= res_nxt_s[63:32];
                res_lo_r <= res_nxt_s[31:0];
            end else if (clr_res_s) begin
                res_hi_r <= 32'd0;
                res_lo_r <= 32'd0;
            end
            if (commit_s) begin
                hi_r <= res_hi_r;
                lo_r <= res_lo_r;
            end else begin
                if (wr_hi_s) hi_r <= rs_data;
                if (wr_lo_s) lo_r <= rs_data;
            end
        end
    end
endmodule
